// File: rtl/turn_sequencer.sv
// Two-player turn controller for the tank game: gates action pulses to the active
// player, enforces the move budget, launches shots, tracks score and declares a winner.
module turn_sequencer #(
    parameter int MOVES_PER_TURN = 3,
    parameter int WIN_SCORE      = 3,
    parameter int SHOT_TIMEOUT   = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_x,
    input  logic       right_x,
    input  logic       left_aim,
    input  logic       right_aim,
    input  logic       shoot_pulse,
    input  logic       new_game,
    input  logic       proj_done,
    input  logic       proj_hit,
    output logic       player,
    output logic       move_l,
    output logic       move_r,
    output logic       aim_l,
    output logic       aim_r,
    output logic       fire,
    output logic       busy,
    output logic [1:0] moves_left,
    output logic [1:0] score_p1,
    output logic [1:0] score_p2,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        FLIGHT,
        SCORE,
        OVER
    } state_t;

    localparam logic [1:0] MOVES_RELOAD  = 2'(MOVES_PER_TURN);
    localparam logic [1:0] WIN_LEVEL     = 2'(WIN_SCORE);
    localparam logic [7:0] TIMEOUT_LEVEL = 8'(SHOT_TIMEOUT);

    state_t     state;
    logic [7:0] timer;
    logic [1:0] active_score;

    assign active_score = player ? score_p2 : score_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            player     <= 1'b0;
            winner     <= 1'b0;
            move_l     <= 1'b0;
            move_r     <= 1'b0;
            aim_l      <= 1'b0;
            aim_r      <= 1'b0;
            fire       <= 1'b0;
            busy       <= 1'b0;
            moves_left <= 2'd0;
            score_p1   <= 2'd0;
            score_p2   <= 2'd0;
            game_over  <= 1'b0;
            timer      <= 8'd0;
        end else begin
            // Strobes are single-cycle: cleared every edge unless re-raised below.
            move_l <= 1'b0;
            move_r <= 1'b0;
            aim_l  <= 1'b0;
            aim_r  <= 1'b0;
            fire   <= 1'b0;

            if (new_game) begin
                state      <= TURN;
                player     <= 1'b0;
                score_p1   <= 2'd0;
                score_p2   <= 2'd0;
                moves_left <= MOVES_RELOAD;
                timer      <= 8'd0;
                busy       <= 1'b0;
                game_over  <= 1'b0;
            end else begin
                case (state)
                    TURN: begin
                        if (shoot_pulse) begin
                            fire  <= 1'b1;
                            busy  <= 1'b1;
                            timer <= 8'd0;
                            state <= FLIGHT;
                        end else if (left_x || right_x) begin
                            // An exhausted budget swallows the pulse entirely.
                            if (moves_left != 2'd0) begin
                                moves_left <= moves_left - 2'd1;
                                move_l     <= left_x;
                                move_r     <= ~left_x;
                            end
                        end else if (left_aim) begin
                            aim_l <= 1'b1;
                        end else if (right_aim) begin
                            aim_r <= 1'b1;
                        end
                    end

                    FLIGHT: begin
                        timer <= timer + 8'd1;
                        if (proj_done) begin
                            if (proj_hit && (active_score != WIN_LEVEL)) begin
                                if (player) begin
                                    score_p2 <= score_p2 + 2'd1;
                                end else begin
                                    score_p1 <= score_p1 + 2'd1;
                                end
                            end
                            state <= SCORE;
                        end else if (timer == TIMEOUT_LEVEL) begin
                            state <= SCORE;
                        end
                    end

                    SCORE: begin
                        busy <= 1'b0;
                        if (active_score == WIN_LEVEL) begin
                            winner    <= player;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            player     <= ~player;
                            moves_left <= MOVES_RELOAD;
                            state      <= TURN;
                        end
                    end

                    IDLE, OVER: begin
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Two-player turn controller for the tank game. It sits between the input-conditioning block, which delivers one-cycle action pulses, and the tank/projectile datapath. It decides whose turn it is and gates each action to the active player. It enforces a per-turn move budget, launches a shot, waits for the projectile engine to resolve it, keeps score and declares the winner.

## Interface
Parameters:
- MOVES_PER_TURN, 3: moves allowed per turn; legal range 1..3.
- WIN_SCORE, 3: hits needed to win; legal range 1..3.
- SHOT_TIMEOUT, 200: cycles spent in FLIGHT before an unresolved shot counts as a miss; legal range 1..255.

Ports (clock and reset first):
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high; forces every register to its reset value.
- left_x, right_x, in, 1: one-cycle move pulses.
- left_aim, right_aim, in, 1: one-cycle aim pulses.
- shoot_pulse, in, 1: one-cycle fire pulse.
- new_game, in, 1: level or pulse; starts or restarts a game.
- proj_done, in, 1: projectile engine has resolved the shot in flight.
- proj_hit, in, 1: hit flag; qualified by proj_done.
- player, out, 1: active player; 0 = P1, 1 = P2.
- move_l, move_r, aim_l, aim_r, out, 1: gated one-cycle strobes applied to the active player's tank.
- fire, out, 1: one-cycle shot launch strobe.
- busy, out, 1: high while the state is FLIGHT or SCORE.
- moves_left, out, 2: remaining move budget for the current turn.
- score_p1, score_p2, out, 2: hit counts.
- game_over, out, 1: high in the OVER state.
- winner, out, 1: winning player; valid while game_over is high.

## Operation
- State machine states: IDLE, TURN, FLIGHT, SCORE, OVER.
- Reset values:
  - state = IDLE.
  - All strobes = 0.
  - player = 0, winner = 0.
  - moves_left = 0.
  - Both scores = 0.
  - busy = 0, game_over = 0.
  - Flight timer = 0.
- new_game has the highest priority in every state. It causes the following at the next edge:
  - state becomes TURN.
  - player = 0, both scores = 0.
  - moves_left = MOVES_PER_TURN, timer = 0.
  - game_over = 0, and all strobes in that cycle = 0.
  - An in-flight shot is abandoned; proj_done arriving afterwards is ignored.
- IDLE: ignores all action inputs and waits for new_game.
- TURN:
  - Only one action is honoured per cycle, with priority shoot_pulse > move (left_x over right_x) > aim (left_aim over right_aim).
  - Move: if moves_left > 0, assert move_l or move_r and decrement moves_left. If moves_left = 0, drop the pulse; no strobe is issued and the counter does not go below 0.
  - Aim: always passed through as aim_l or aim_r; costs no budget.
  - Shoot: assert fire, go to FLIGHT, clear the timer.
- FLIGHT:
  - All action inputs are dropped.
  - The timer increments every cycle.
  - proj_done with proj_hit = 1: increment the active player's score, go to SCORE.
  - proj_done with proj_hit = 0: go to SCORE with no score change.
  - Timer equal to SHOT_TIMEOUT with no proj_done: treated as a miss, go to SCORE.
  - proj_done in the same cycle as the timeout: proj_done wins.
- SCORE (one cycle):
  - If the active player's score equals WIN_SCORE: go to OVER and set winner = player.
  - Otherwise: toggle player, reload moves_left = MOVES_PER_TURN, go to TURN.
- OVER:
  - game_over = 1.
  - Scores, winner and player are held.
  - Action inputs are dropped; only new_game leaves this state.
- Scores are 2-bit and never exceed WIN_SCORE, so they cannot wrap.

## Timing
- All outputs are registered.
- Strobes (move_l, move_r, aim_l, aim_r, fire) are high for exactly one cycle. They appear in the cycle after the input pulse is sampled.
- moves_left decrements at the same edge that raises the corresponding move strobe.
- busy rises at the same edge as fire and falls on the edge that leaves SCORE.
- Turn handover: proj_done is sampled at edge N, the score updates at edge N, and player toggles and TURN is entered at edge N+1.
- Game end: game_over rises at edge N+1 after the winning proj_done.
- Timeout: with no proj_done, the miss is taken SHOT_TIMEOUT+1 edges after the fire edge.
- Reset asserted mid-FLIGHT or mid-SCORE clears everything immediately, without waiting for a clock edge.

## Test plan
- Reset, then new_game pulse: player=0, moves_left=3, scores 0/0, game_over=0, all strobes 0.
- In TURN, four left_x pulses spaced 2 cycles apart: three move_l strobes, moves_left goes 3→2→1→0, fourth pulse produces no strobe and moves_left stays 0. An aim_r pulse afterwards still yields aim_r.
- shoot_pulse: fire high one cycle later and busy=1. Action pulses during FLIGHT produce no strobes. proj_done=1 with proj_hit=1 gives score_p1=1, then player=1 and moves_left=3 on the next edge.
- shoot_pulse, then no proj_done: miss taken after the timeout, scores unchanged, player toggles. Repeat with proj_done asserted exactly on the timeout cycle: proj_done resolves the shot.
- P1 reaches 3 hits: game_over=1, winner=0. Pulses on every action input then give no strobes. A new_game pulse restarts with scores 0/0 and player=0.
- new_game asserted mid-FLIGHT: next edge gives TURN with player=0, scores 0/0, busy=0, and a later proj_done has no effect. Separately, async reset mid-FLIGHT clears all outputs without a clock edge.
